// File: rtl/mult_accumulator_if.sv
// Product-stream and result ports of the packet accumulator, grouped as one bundle.
// master drives beats and out_ready; slave is the accumulator.
interface mult_accumulator_if #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_ACC = 72,
    parameter int CNT_W     = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_IN-1:0]  in_data;
    logic                 in_signed;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_ACC-1:0] out_data;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mult_accumulator.sv
// Sums multiplier products into in_last-delimited packets, one result per packet with
// guard bits and a sticky overflow flag. Define MULT_ACCUMULATOR_SAT_EN to clamp instead of wrap.
module mult_accumulator #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_ACC = 72,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    mult_accumulator_if.slave bus
);
    localparam int W = WIDTH_ACC;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, state_next;
    logic [W-1:0]     acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ovf, ovf_next, ovf_now;
    logic             sgn, sgn_eff;
    logic             take, emit;
    logic [W:0]       base_ext, in_ext, sum;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign take         = bus.in_valid && bus.in_ready;
    assign emit         = take && bus.in_last;
    // Signedness is taken from the first beat; later beats follow the latched value.
    assign sgn_eff      = (state == IDLE) ? bus.in_signed : sgn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        state_next = state;
        base_ext   = (state == ACCUM) ? {sgn_eff & acc[W-1], acc} : '0;
        in_ext     = {{(W + 1 - WIDTH_IN){sgn_eff & bus.in_data[WIDTH_IN-1]}}, bus.in_data};
        sum        = base_ext + in_ext;
        ovf_now    = sgn_eff ? (sum[W] ^ sum[W-1]) : sum[W];
        acc_next   = sum[W-1:0];
`ifdef MULT_ACCUMULATOR_SAT_EN
        if (ovf_now) begin
            if (sgn_eff)
                acc_next = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
                acc_next = '1;
        end
`endif
        if (state == IDLE)
            cnt_next = CNT_W'(1);
        else
            cnt_next = (&cnt) ? cnt : cnt + 1'b1;
        ovf_next = ((state == ACCUM) && ovf) || ovf_now;
        if (take)
            state_next = bus.in_last ? IDLE : ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            sgn           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (take) begin
            if (state == IDLE)
                sgn <= bus.in_signed;
            if (emit) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= acc_next;
                bus.out_count <= cnt_next;
                bus.out_ovf   <= ovf_next;
                acc           <= '0;
                cnt           <= '0;
                ovf           <= 1'b0;
            end else begin
                // A non-emitting transfer can only happen with out_ready high or no result held.
                if (bus.out_ready)
                    bus.out_valid <= 1'b0;
                acc <= acc_next;
                cnt <= cnt_next;
                ovf <= ovf_next;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
